// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Round-robin front end that shares one signed W x W pipelined multiplier
//   (MUL_LAT cycles, registered output) among N_REQ requesters. Each issued op
//   is tracked by a MUL_LAT-deep {valid,id,ovf} shift register. When a tracked
//   op leaves the tracker, its product is captured into a show-ahead response
//   FIFO. Responses come back in issue order.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake; operands in req_a/req_b
//                             (requester i at [i*W +: W])
//   mul_en/mul_a/mul_b/mul_p  multiplier control, operands and product
//   rsp_valid/rsp_ready       response handshake; rsp_id/rsp_p/rsp_ovf give
//                             the FIFO head
//   busy                      op in flight or response queued
module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 15,
    parameter int MUL_LAT = 1,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 mul_en,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-2:0]       mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2*W-2:0]       rsp_p,
    output logic                 rsp_ovf,
    output logic                 busy
);
    localparam int PW         = 2*W-1;
    localparam int FIFO_DEPTH = MUL_LAT+2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH+1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef struct packed { logic [ID_W-1:0] id; logic ovf; } trk_t;
    typedef struct packed { logic [ID_W-1:0] id; logic ovf; logic [PW-1:0] p; } ent_t;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [MUL_LAT:1]   vld_pipe_q, vld_pipe_d;
    trk_t [MUL_LAT:1]   trk_q, trk_d;
    ent_t               mem_q [FIFO_DEPTH];
    ent_t               mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, infl_cnt;

    logic               credit, gnt_found, accept, ovf_in, push, pop;
    logic [ID_W-1:0]    gnt_idx, cand;
    ent_t               head;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts both ops still in the multiplier and queued responses, so
    // every issued op is guaranteed a FIFO slot. A pop in the same cycle does
    // not count, which keeps req_ready independent of rsp_ready.
    always_comb begin
        infl_cnt = '0;
        for (int s = 1; s <= MUL_LAT; s++) infl_cnt = infl_cnt + CNT_W'(vld_pipe_q[s]);
        credit = ({1'b0, infl_cnt} + {1'b0, cnt_q}) < (CNT_W+1)'(FIFO_DEPTH);
    end

    // Round-robin search starting at ptr_q.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = ID_W'((int'(ptr_q) + off) % N_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (!rst && credit && gnt_found) req_ready[gnt_idx] = 1'b1;
        accept = |(req_valid & req_ready);
        if (accept) begin
            mul_a = req_a[int'(gnt_idx)*W +: W];
            mul_b = req_b[int'(gnt_idx)*W +: W];
        end
        ovf_in = accept && (mul_a == MOST_NEG) && (mul_b == MOST_NEG);
        mul_en = ~rst;
        ptr_d  = ptr_q;
        if (accept) ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    // Tracker: the multiplier free-runs, so slot validity lives here.
    always_comb begin
        vld_pipe_d        = vld_pipe_q;
        trk_d             = trk_q;
        vld_pipe_d[1]     = accept;
        trk_d[1].id       = gnt_idx;
        trk_d[1].ovf      = ovf_in;
        for (int s = 2; s <= MUL_LAT; s++) begin
            vld_pipe_d[s] = vld_pipe_q[s-1];
            trk_d[s]      = trk_q[s-1];
        end
    end

    // The last tracker stage lines up with mul_p in the same cycle.
    assign push = vld_pipe_q[MUL_LAT];
    assign pop  = rsp_valid & rsp_ready;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q].id  = trk_q[MUL_LAT].id;
            mem_d[wr_q].ovf = trk_q[MUL_LAT].ovf;
            mem_d[wr_q].p   = mul_p;
            wr_d            = nxt(wr_q);
        end
        if (pop) rd_d = nxt(rd_q);
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            vld_pipe_q <= '0;
            trk_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q      <= ptr_d;
            vld_pipe_q <= vld_pipe_d;
            trk_q      <= trk_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign head      = mem_q[rd_q];
    assign rsp_valid = ~rst & (cnt_q != '0);
    assign rsp_id    = rsp_valid ? head.id  : '0;
    assign rsp_p     = rsp_valid ? head.p   : '0;
    assign rsp_ovf   = rsp_valid ? head.ovf : 1'b0;
    assign busy      = ~rst & ((|vld_pipe_q) | (cnt_q != '0));

    // The credit rule makes a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (rst) !(push && cnt_q == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;
  localparam int N = 4, W = 15, PW = 2*W-1, ID_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rsp_ready;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_a, req_b;

  logic [N-1:0] req_ready_1, req_ready_3;
  logic mul_en_1, mul_en_3, rsp_valid_1, rsp_valid_3, rsp_ovf_1, rsp_ovf_3, busy_1, busy_3;
  logic [W-1:0] mul_a_1, mul_b_1, mul_a_3, mul_b_3;
  logic [PW-1:0] mul_p_1, mul_p_3, rsp_p_1, rsp_p_3;
  logic [ID_W-1:0] rsp_id_1, rsp_id_3;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] x, y;
    x = {{(PW-W){a[W-1]}}, a};
    y = {{(PW-W){b[W-1]}}, b};
    return x * y;
  endfunction

  mul_share_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(1), .ID_W(ID_W)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready_1), .mul_en(mul_en_1), .mul_a(mul_a_1), .mul_b(mul_b_1), .mul_p(mul_p_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready), .rsp_id(rsp_id_1), .rsp_p(rsp_p_1),
    .rsp_ovf(rsp_ovf_1), .busy(busy_1));

  mul_share_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(3), .ID_W(ID_W)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready_3), .mul_en(mul_en_3), .mul_a(mul_a_3), .mul_b(mul_b_3), .mul_p(mul_p_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready), .rsp_id(rsp_id_3), .rsp_p(rsp_p_3),
    .rsp_ovf(rsp_ovf_3), .busy(busy_3));

  // multiplier models: en-gated, registered output
  logic [PW-1:0] p1_q = '0;
  logic [PW-1:0] p3_q [3] = '{default: '0};
  always @(posedge clk) if (mul_en_1) p1_q <= mul_ref(mul_a_1, mul_b_1);
  always @(posedge clk) if (mul_en_3) begin
    p3_q[0] <= mul_ref(mul_a_3, mul_b_3);
    p3_q[1] <= p3_q[0];
    p3_q[2] <= p3_q[1];
  end
  assign mul_p_1 = p1_q;
  assign mul_p_3 = p3_q[2];

  // scoreboards: expected responses in accept order
  typedef struct { logic [ID_W-1:0] id; logic ovf; logic [PW-1:0] p; } exp_t;
  exp_t q1[$], q3[$];
  exp_t e1, e3;

  function automatic exp_t mk_exp(input int i);
    exp_t e;
    logic [W-1:0] a, b;
    a = req_a[i*W +: W];
    b = req_b[i*W +: W];
    e.id  = ID_W'(i);
    e.ovf = (a == 15'h4000) && (b == 15'h4000);
    e.p   = mul_ref(a, b);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) q1.delete();
    else begin
      chk("onehot1", $onehot0(req_ready_1), 1);
      if (rsp_valid_1 && rsp_ready) begin
        chk("sb1_nonempty", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          chk("sb1_id", rsp_id_1, e1.id);
          chk("sb1_p", $signed(rsp_p_1), $signed(e1.p));
          chk("sb1_ovf", rsp_ovf_1, e1.ovf);
        end
      end
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready_1[i]) q1.push_back(mk_exp(i));
    end
  end

  always @(negedge clk) begin
    if (rst) q3.delete();
    else begin
      chk("onehot3", $onehot0(req_ready_3), 1);
      if (rsp_valid_3 && rsp_ready) begin
        chk("sb3_nonempty", q3.size() > 0, 1);
        if (q3.size() > 0) begin
          e3 = q3.pop_front();
          chk("sb3_id", rsp_id_3, e3.id);
          chk("sb3_p", $signed(rsp_p_3), $signed(e3.p));
          chk("sb3_ovf", rsp_ovf_3, e3.ovf);
        end
      end
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready_3[i]) q3.push_back(mk_exp(i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int c);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 15'(c*523 + i*3001 - 7000);
      req_b[i*W +: W] = 15'(i*977 - c*311 + 123);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_1 || busy_3) && n < 60) begin
      tick();
      n++;
    end
    @(negedge clk);
    chk("idle", busy_1 | busy_3, 0);
    tick();
  endtask

  task automatic one_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_p, input int exp_ovf);
    bit found = 0;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid = 4'(1 << idx);
    @(negedge clk);
    chk("t4_acc", req_ready_1[idx], 1);
    tick();
    req_valid = '0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (rsp_valid_1) begin
        found = 1;
        chk("t4_id", rsp_id_1, idx);
        chk("t4_p", $signed(rsp_p_1), exp_p);
        chk("t4_ovf", rsp_ovf_1, exp_ovf);
      end
      tick();
    end
    chk("t4_seen", found, 1);
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int acc1, acc3;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_ready1", req_ready_1, 0);
    chk("rst_ready3", req_ready_3, 0);
    chk("rst_en1", mul_en_1, 0);
    chk("rst_en3", mul_en_3, 0);
    chk("rst_mula1", mul_a_1, 0);
    chk("rst_vld1", rsp_valid_1, 0);
    chk("rst_p1", rsp_p_1, 0);
    chk("rst_busy1", busy_1, 0);
    chk("rst_busy3", busy_3, 0);

    // 1: single op from requester 0, latency check on both pipelines
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    req_a[W-1:0] = 15'(3); req_b[W-1:0] = 15'(-5); req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_gnt1", req_ready_1, 1);
    chk("t1_gnt3", req_ready_3, 1);
    chk("t1_en1", mul_en_1, 1);
    chk("t1_mula1", $signed(mul_a_1), 3);
    tick();
    req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t1_vld1", rsp_valid_1, c == 2);
      chk("t1_vld3", rsp_valid_3, c == 4);
      if (c == 2) begin
        chk("t1_id1", rsp_id_1, 0);
        chk("t1_p1", $signed(rsp_p_1), -15);
        chk("t1_ovf1", rsp_ovf_1, 0);
      end
      if (c == 4) chk("t1_p3", $signed(rsp_p_3), -15);
      tick();
    end

    // 2: all requesting from reset, rsp_ready=1
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      set_ops(c);
      @(negedge clk);
      chk("t2_gnt1", req_ready_1, 1 << (c % 4));
      chk("t2_gnt3", req_ready_3, 1 << (c % 4));
      if (c >= 2) chk("t2_nobub1", rsp_valid_1, 1);
      if (c >= 4) chk("t2_nobub3", rsp_valid_3, 1);
      tick();
    end
    req_valid = '0;
    wait_idle();

    // 3: backpressure fills to FIFO_DEPTH, then drains and resumes
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    acc1 = 0; acc3 = 0;
    for (int c = 0; c < 12; c++) begin
      set_ops(c + 20);
      @(negedge clk);
      acc1 += $countones(req_valid & req_ready_1);
      acc3 += $countones(req_valid & req_ready_3);
      tick();
    end
    chk("t3_acc1", acc1, 3);
    chk("t3_acc3", acc3, 5);
    @(negedge clk);
    chk("t3_stall1", req_ready_1, 0);
    chk("t3_stall3", req_ready_3, 0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_nocred1", req_ready_1, 0);
    chk("t3_nocred3", req_ready_3, 0);
    chk("t3_drain1", rsp_valid_1, 1);
    tick();
    @(negedge clk);
    chk("t3_resume1", req_ready_1 != 0, 1);
    chk("t3_resume3", req_ready_3 != 0, 1);
    chk("t3_drain3", rsp_valid_3, 1);
    tick();
    tick();
    req_valid = '0;
    wait_idle();

    // 4: operand extremes
    one_op(2, 15'h4000, 15'h4000, -268435456, 1);
    one_op(2, 15'h4000, 15'h3fff, -268419072, 0);
    one_op(1, 15'h3fff, 15'h3fff, 268402689, 0);

    // 5: reset with ops in flight and queued
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    set_ops(40);
    for (int c = 0; c < 4; c++) tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_pre_ready1", req_ready_1, 0);
    chk("t5_vld1", rsp_valid_1, 0);
    chk("t5_vld3", rsp_valid_3, 0);
    chk("t5_busy3", busy_3, 0);
    chk("t5_en3", mul_en_3, 0);
    chk("t5_id3", rsp_id_3, 0);
    chk("t5_p3", rsp_p_3, 0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5_stale1", rsp_valid_1 | busy_1, 0);
      chk("t5_stale3", rsp_valid_3 | busy_3, 0);
      tick();
    end
    set_ops(50);
    req_a[W-1:0] = 15'(-7); req_b[W-1:0] = 15'(1234);
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t5_gnt1", req_ready_1, 1);
    chk("t5_gnt3", req_ready_3, 1);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("t5_rvld1", rsp_valid_1, 1);
    chk("t5_rid1", rsp_id_1, 0);
    chk("t5_rp1", $signed(rsp_p_1), -8638);
    tick();
    wait_idle();

    chk("sb1_left", q1.size(), 0);
    chk("sb3_left", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
